// File: rtl/bingo_line_checker_if.sv
// -----------------------------------------------------------------------------
// bingo_line_checker_if
// Groups the check request/result signals of the bingo line checker.
//   check_start  : one-cycle request to evaluate circle
//   circle       : 25-bit marked-position bitmap (bit p = row*5 + col)
//   send_ack     : interboard transmitter accepted the win message
//   line_count   : completed lines from the last finished check
//   lines_mask   : completed-line flags from the last finished check
//   win          : sticky win flag
//   send_win_req : request to transmit a STATE_WIN message
//   check_done   : one-cycle pulse marking the end of a check
// Modports: master (requester side), slave (checker side).
// -----------------------------------------------------------------------------
interface bingo_line_checker_if;
    logic        check_start;
    logic [24:0] circle;
    logic        send_ack;
    logic [3:0]  line_count;
    logic [11:0] lines_mask;
    logic        win;
    logic        send_win_req;
    logic        check_done;

    modport master (
        output check_start,
        output circle,
        output send_ack,
        input  line_count,
        input  lines_mask,
        input  win,
        input  send_win_req,
        input  check_done
    );

    modport slave (
        input  check_start,
        input  circle,
        input  send_ack,
        output line_count,
        output lines_mask,
        output win,
        output send_win_req,
        output check_done
    );
endinterface

// File: rtl/bingo_line_checker.sv
// -----------------------------------------------------------------------------
// bingo_line_checker
// Snapshots a 5x5 bingo card bitmap on check_start, scans the 12 possible
// lines (5 rows, 5 columns, 2 diagonals) one per cycle, publishes the count
// and mask, raises a sticky win once the count reaches WIN_LINES and asks the
// interboard transmitter to send a win message the first time that happens.
// Ports:
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   interboard_rst : synchronous active-high clear (same values as rst_n)
//   bus            : slave side of bingo_line_checker_if
// -----------------------------------------------------------------------------
module bingo_line_checker #(
    parameter int WIN_LINES = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                interboard_rst,
    bingo_line_checker_if.slave bus
);

    localparam logic [3:0] WIN_THR   = 4'(WIN_LINES);
    localparam logic [3:0] LAST_LINE = 4'd11;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        EVAL,
        REPORT,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [24:0] snap;
    logic [3:0]  idx;
    logic [3:0]  acc_count;
    logic [11:0] acc_mask;
    logic [3:0]  line_count;
    logic [11:0] lines_mask;
    logic        win;
    logic        send_win_req;
    logic        check_done;
    logic        hit;

    // Card positions belonging to each line index.
    function automatic logic [24:0] line_bits(input logic [3:0] i);
        logic [24:0] m;
        case (i)
            4'd0:    m = 25'h000001F;
            4'd1:    m = 25'h00003E0;
            4'd2:    m = 25'h0007C00;
            4'd3:    m = 25'h00F8000;
            4'd4:    m = 25'h1F00000;
            4'd5:    m = 25'h0108421;
            4'd6:    m = 25'h0210842;
            4'd7:    m = 25'h0421084;
            4'd8:    m = 25'h0842108;
            4'd9:    m = 25'h1084210;
            4'd10:   m = 25'h1041041;
            4'd11:   m = 25'h0111110;
            default: m = 25'h0000000;
        endcase
        return m;
    endfunction

    assign hit = ((snap & line_bits(idx)) == line_bits(idx));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.check_start) state_nxt = SCAN;
            SCAN:    if (idx == LAST_LINE) state_nxt = EVAL;
            EVAL:    state_nxt = (acc_count >= WIN_THR && !win) ? REPORT : DONE;
            REPORT:  if (bus.send_ack) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            snap         <= '0;
            idx          <= '0;
            acc_count    <= '0;
            acc_mask     <= '0;
            line_count   <= '0;
            lines_mask   <= '0;
            win          <= 1'b0;
            send_win_req <= 1'b0;
            check_done   <= 1'b0;
        end else if (interboard_rst) begin
            state        <= IDLE;
            snap         <= '0;
            idx          <= '0;
            acc_count    <= '0;
            acc_mask     <= '0;
            line_count   <= '0;
            lines_mask   <= '0;
            win          <= 1'b0;
            send_win_req <= 1'b0;
            check_done   <= 1'b0;
        end else begin
            state <= state_nxt;
            // Moore outputs registered from the next state so they line up
            // exactly with REPORT / DONE occupancy.
            send_win_req <= (state_nxt == REPORT);
            check_done   <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (bus.check_start) begin
                        snap      <= bus.circle;
                        idx       <= '0;
                        acc_count <= '0;
                        acc_mask  <= '0;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        acc_mask[idx] <= 1'b1;
                        acc_count     <= acc_count + 4'd1;
                    end
                    idx <= idx + 4'd1;
                end
                EVAL: begin
                    line_count <= acc_count;
                    lines_mask <= acc_mask;
                    if (state_nxt == REPORT) win <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.line_count   = line_count;
    assign bus.lines_mask   = lines_mask;
    assign bus.win          = win;
    assign bus.send_win_req = send_win_req;
    assign bus.check_done   = check_done;

endmodule

// File: tb/tb_bingo_line_checker.sv
// -----------------------------------------------------------------------------
// tb_bingo_line_checker
// Directed, table-driven bench for bingo_line_checker (WIN_LINES = 5).
// Inputs change and outputs are sampled on the falling clock edge; cycle n
// after a check_start is the n-th falling edge after the sampling rising edge.
// -----------------------------------------------------------------------------
module tb_bingo_line_checker;

    logic clk = 1'b0;
    logic rst_n;
    logic interboard_rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    bingo_line_checker_if bus();

    bingo_line_checker #(.WIN_LINES(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .interboard_rst(interboard_rst),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [24:0] circle;
        int          ack_delay;
        logic [3:0]  exp_count;
        logic [11:0] exp_mask;
        logic        exp_win;
        int          exp_done;
        int          exp_reqs;
    } vec_t;

    vec_t vec[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge one cycle after the
    // check_done pulse (or after the cycle budget runs out).
    task automatic run_check(input logic [24:0] c, input int ack_delay,
                             output int done_cyc, output int req_cyc,
                             output logic held, output logic done_after);
        logic [3:0]  pc;
        logic [11:0] pm;
        pc = bus.line_count;
        pm = bus.lines_mask;
        done_cyc = -1;
        req_cyc = 0;
        held = 1'b1;
        done_after = 1'b1;
        bus.circle = c;
        bus.check_start = 1'b1;
        @(negedge clk);
        bus.check_start = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (n <= 13 && (bus.line_count !== pc || bus.lines_mask !== pm)) held = 1'b0;
            if (bus.send_win_req) begin
                req_cyc++;
                bus.send_ack = (req_cyc == ack_delay + 1);
            end else begin
                bus.send_ack = 1'b0;
            end
            if (bus.check_done) begin
                done_cyc = n;
                break;
            end
            @(negedge clk);
        end
        bus.send_ack = 1'b0;
        @(negedge clk);
        done_after = bus.check_done;
    endtask

    int   dc, rc, dones, first, reqs;
    logic held, da;

    initial begin
        vec[0] = '{"zero",      25'h0000000, -1, 4'd0,  12'h000, 1'b0, 14, 0};
        vec[1] = '{"row0",      25'h000001F, -1, 4'd1,  12'h001, 1'b0, 14, 0};
        vec[2] = '{"diags",     25'h1151151, -1, 4'd2,  12'hC00, 1'b0, 14, 0};
        vec[3] = '{"rows0to3",  25'h00FFFFF, -1, 4'd4,  12'h00F, 1'b0, 14, 0};
        vec[4] = '{"row4col2",  25'h1F21084, -1, 4'd2,  12'h090, 1'b0, 14, 0};
        vec[5] = '{"full_win",  25'h1FFFFFF,  3, 4'd12, 12'hFFF, 1'b1, 18, 4};
        vec[6] = '{"full_rep",  25'h1FFFFFF,  3, 4'd12, 12'hFFF, 1'b1, 14, 0};

        rst_n = 1'b0;
        interboard_rst = 1'b0;
        bus.check_start = 1'b0;
        bus.circle = '0;
        bus.send_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rst line_count", {28'd0, bus.line_count}, 32'd0);
        check("rst lines_mask", {20'd0, bus.lines_mask}, 32'd0);
        check("rst win", {31'd0, bus.win}, 32'd0);
        check("rst send_win_req", {31'd0, bus.send_win_req}, 32'd0);
        check("rst check_done", {31'd0, bus.check_done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst check_done", {31'd0, bus.check_done}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_check(vec[i].circle, vec[i].ack_delay, dc, rc, held, da);
            check($sformatf("%s done_cycle", vec[i].name), dc, vec[i].exp_done);
            check($sformatf("%s req_cycles", vec[i].name), rc, vec[i].exp_reqs);
            check($sformatf("%s line_count", vec[i].name), {28'd0, bus.line_count}, {28'd0, vec[i].exp_count});
            check($sformatf("%s lines_mask", vec[i].name), {20'd0, bus.lines_mask}, {20'd0, vec[i].exp_mask});
            check($sformatf("%s win", vec[i].name), {31'd0, bus.win}, {31'd0, vec[i].exp_win});
            check($sformatf("%s outputs held in scan", vec[i].name), {31'd0, held}, 32'd1);
            check($sformatf("%s done one cycle", vec[i].name), {31'd0, da}, 32'd0);
        end

        // Circle change and a second check_start during SCAN are ignored.
        bus.circle = 25'h000001F;
        bus.check_start = 1'b1;
        @(negedge clk);
        bus.check_start = 1'b0;
        dones = 0;
        first = -1;
        for (int n = 1; n <= 30; n++) begin
            if (n == 5) begin
                bus.circle = 25'h1FFFFFF;
                bus.check_start = 1'b1;
            end else if (n == 6) begin
                bus.check_start = 1'b0;
            end
            if (bus.check_done) begin
                dones++;
                if (first < 0) first = n;
            end
            @(negedge clk);
        end
        check("snap done_cycle", first, 32'd14);
        check("snap done_pulses", dones, 32'd1);
        check("snap line_count", {28'd0, bus.line_count}, 32'd1);
        check("snap lines_mask", {20'd0, bus.lines_mask}, 32'h001);
        check("snap win sticky", {31'd0, bus.win}, 32'd1);

        // interboard_rst in the middle of SCAN.
        bus.circle = 25'h1FFFFFF;
        bus.check_start = 1'b1;
        @(negedge clk);
        bus.check_start = 1'b0;
        repeat (5) @(negedge clk);
        interboard_rst = 1'b1;
        @(negedge clk);
        interboard_rst = 1'b0;
        check("ibrst line_count", {28'd0, bus.line_count}, 32'd0);
        check("ibrst lines_mask", {20'd0, bus.lines_mask}, 32'd0);
        check("ibrst win", {31'd0, bus.win}, 32'd0);
        check("ibrst send_win_req", {31'd0, bus.send_win_req}, 32'd0);
        dones = 0;
        for (int n = 0; n < 20; n++) begin
            if (bus.check_done) dones++;
            @(negedge clk);
        end
        check("ibrst no check_done", dones, 32'd0);

        // Exactly WIN_LINES lines wins; immediate ack.
        run_check(25'h04FFFFF, 0, dc, rc, held, da);
        check("thr done_cycle", dc, 32'd15);
        check("thr req_cycles", rc, 32'd1);
        check("thr line_count", {28'd0, bus.line_count}, 32'd5);
        check("thr lines_mask", {20'd0, bus.lines_mask}, 32'h08F);
        check("thr win", {31'd0, bus.win}, 32'd1);

        // Clear the win, then pull rst_n low while waiting in REPORT.
        interboard_rst = 1'b1;
        @(negedge clk);
        interboard_rst = 1'b0;
        bus.circle = 25'h1FFFFFF;
        bus.check_start = 1'b1;
        @(negedge clk);
        bus.check_start = 1'b0;
        repeat (15) @(negedge clk);
        check("rep send_win_req before rst", {31'd0, bus.send_win_req}, 32'd1);
        check("rep win before rst", {31'd0, bus.win}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst send_win_req", {31'd0, bus.send_win_req}, 32'd0);
        check("arst win", {31'd0, bus.win}, 32'd0);
        check("arst line_count", {28'd0, bus.line_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        reqs = 0;
        for (int n = 0; n < 20; n++) begin
            if (bus.check_done) dones++;
            if (bus.send_win_req) reqs++;
            @(negedge clk);
        end
        check("arst no check_done", dones, 32'd0);
        check("arst no send_win_req", reqs, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
